// File: rtl/us_cmd_pkg.sv
// Shared definitions for the ultrasound command transmitter: request layout,
// opcode set, per-opcode payload field widths, command word layout and FSM states.
package us_cmd_pkg;

    // Command word layout: {hw_ch, sub_ch[2:0], op[3:0], payload[23:0]}
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORD_HW_CH_BIT = 31;
    localparam int unsigned WORD_SUB_LSB   = 28;
    localparam int unsigned WORD_OP_LSB    = 24;
    localparam int unsigned PAYLOAD_W      = 24;
    localparam int unsigned MASK_W         = 8;
    localparam int unsigned OP_W           = 4;
    localparam int unsigned REQ_W          = 1 + MASK_W + OP_W + PAYLOAD_W;

    // Legal parameter opcodes
    localparam logic [3:0] OP_01 = 4'h1;
    localparam logic [3:0] OP_02 = 4'h2;
    localparam logic [3:0] OP_03 = 4'h3;
    localparam logic [3:0] OP_04 = 4'h4;
    localparam logic [3:0] OP_05 = 4'h5;
    localparam logic [3:0] OP_06 = 4'h6;
    localparam logic [3:0] OP_07 = 4'h7;
    localparam logic [3:0] OP_09 = 4'h9;
    localparam logic [3:0] OP_0A = 4'hA;
    localparam logic [3:0] OP_0B = 4'hB;
    localparam logic [3:0] OP_0C = 4'hC;

    // One queued request as it sits in the FIFO (37 bits)
    typedef struct packed {
        logic                 hw_ch;
        logic [MASK_W-1:0]    ch_mask;
        logic [OP_W-1:0]      op;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_GAP  = 2'd3
    } cmd_state_e;

    // Payload field width per opcode; 0 marks an illegal opcode
    function automatic logic [4:0] op_field_width(input logic [3:0] op);
        logic [4:0] w;
        case (op)
            OP_01:   w = 5'd11;
            OP_02:   w = 5'd20;
            OP_03:   w = 5'd20;
            OP_04:   w = 5'd16;
            OP_05:   w = 5'd8;
            OP_06:   w = 5'd16;
            OP_07:   w = 5'd3;
            OP_09:   w = 5'd11;
            OP_0A:   w = 5'd10;
            OP_0B:   w = 5'd3;
            OP_0C:   w = 5'd22;
            default: w = 5'd0;
        endcase
        return w;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return op_field_width(op) != 5'd0;
    endfunction

    // Index of the lowest set mask bit (ascending sub-channel order)
    function automatic logic [2:0] lowest_sub_ch(input logic [MASK_W-1:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Assemble a command word, clearing payload bits above the opcode's field
    function automatic logic [WORD_W-1:0] build_word(input logic                 hw_ch,
                                                      input logic [2:0]           sub_ch,
                                                      input logic [OP_W-1:0]      op,
                                                      input logic [PAYLOAD_W-1:0] payload);
        logic [WORD_W-1:0]    word;
        logic [PAYLOAD_W-1:0] keep;
        keep = (24'd1 << op_field_width(op)) - 24'd1;
        word = '0;
        word[WORD_HW_CH_BIT]        = hw_ch;
        word[WORD_SUB_LSB +: 3]     = sub_ch;
        word[WORD_OP_LSB +: OP_W]   = op;
        word[PAYLOAD_W-1:0]         = payload & keep;
        return word;
    endfunction

endpackage

// File: rtl/us_cmd_fifo.sv
// Synchronous request FIFO with full/empty flags. Pushes while full and pops
// while empty are ignored; the head entry is presented combinationally.
module us_cmd_fifo
    import us_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = REQ_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/us_cmd_tx.sv
// Command transmitter: queues parameter-write requests and expands each one
// into one 32-bit command word per selected sub-channel, with optional idle
// gap between words and an emission inhibit (i_hold).
module us_cmd_tx
    import us_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP        = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_vld,
    output logic                 o_req_rdy,
    input  logic                 i_req_hw_ch,
    input  logic [MASK_W-1:0]    i_req_ch_mask,
    input  logic [OP_W-1:0]      i_req_op,
    input  logic [PAYLOAD_W-1:0] i_req_payload,
    input  logic                 i_hold,
    output logic [WORD_W-1:0]    o_cmd_data,
    output logic                 o_cmd_vld,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned GAP_CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    cmd_req_t   req_in;
    cmd_req_t   fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    cmd_state_e            state_q, state_d;
    cmd_req_t              req_q, req_d;
    logic [MASK_W-1:0]     mask_q, mask_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0]     cmd_data_q, cmd_data_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic                  err_q, err_d;

    cmd_req_t              cur_req;
    logic [MASK_W-1:0]     cur_mask;
    logic [MASK_W-1:0]     rest_mask;
    logic                  head_ok;
    logic                  can_emit;

    assign req_in = '{hw_ch:   i_req_hw_ch,
                      ch_mask: i_req_ch_mask,
                      op:      i_req_op,
                      payload: i_req_payload};

    // No push-through when full: readiness depends only on the full flag
    assign o_req_rdy = ~fifo_full;
    assign push      = i_req_vld & ~fifo_full;

    us_cmd_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (push),
        .i_data  (req_in),
        .i_pop   (pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // In LOAD the first word is built straight from the FIFO head so that an
    // accepted request reaches the output two cycles later.
    assign cur_req   = (state_q == ST_LOAD) ? fifo_head : req_q;
    assign cur_mask  = (state_q == ST_LOAD) ? fifo_head.ch_mask : mask_q;
    assign rest_mask = cur_mask & (cur_mask - 1'b1);
    assign head_ok   = op_is_legal(fifo_head.op) && (fifo_head.ch_mask != '0);
    assign can_emit  = !i_hold &&
                       (((state_q == ST_LOAD) && head_ok) || (state_q == ST_EMIT));

    assign o_busy     = !fifo_empty || (state_q != ST_IDLE);
    assign o_cmd_data = cmd_data_q;
    assign o_cmd_vld  = cmd_vld_q;
    assign o_err      = err_q;

    // Next-state, expansion and output word computation
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mask_d     = mask_q;
        gap_cnt_d  = gap_cnt_q;
        cmd_data_d = cmd_data_q;
        cmd_vld_d  = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A push this cycle guarantees a valid head in LOAD next cycle
                if (!fifo_empty || push) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop    = 1'b1;
                req_d  = fifo_head;
                mask_d = fifo_head.ch_mask;
                if (head_ok) begin
                    state_d = ST_EMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // Held: stay here with the mask untouched
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = (mask_q != '0) ? ST_EMIT : ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (can_emit) begin
            cmd_data_d = build_word(cur_req.hw_ch, lowest_sub_ch(cur_mask),
                                    cur_req.op, cur_req.payload);
            cmd_vld_d  = 1'b1;
            mask_d     = rest_mask;
            if (GAP > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_LOAD;
            end else begin
                state_d = (rest_mask != '0) ? ST_EMIT : ST_IDLE;
            end
        end
    end

    // FSM state, remaining mask, gap counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            gap_cnt_q  <= '0;
            cmd_data_q <= '0;
            cmd_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            gap_cnt_q  <= gap_cnt_d;
            cmd_data_q <= cmd_data_d;
            cmd_vld_q  <= cmd_vld_d;
            err_q      <= err_d;
        end
    end

    // Latched request fields (data only, qualified by state)
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

endmodule
